data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit words; SHALL be a power of two >= 4.
REQ-002 Parameter READ_LATENCY, default 1: cycles from request acceptance to read response; legal values 1 and 2 only.
REQ-003 Parameter INIT_FILE, default "": hex image loaded into the array at elaboration; empty means all words zero.
REQ-004 Derived AW = clog2(DEPTH)+2: byte-address width.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  controller can accept a request.
REQ-009 req_we  in  1  1 = store, 0 = load.
REQ-010 req_size  in  2  00 byte, 01 halfword, 10 word; 11 illegal.
REQ-011 req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-012 req_addr  in  AW  byte address; byte 0 = bits 7:0 of the word (little-endian lanes).
REQ-013 req_wdata  in  32  store data, right-justified.
REQ-014 rsp_valid  out  1  response present.
REQ-015 rsp_ready  in  1  consumer accepts the response.
REQ-016 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-017 rsp_err  out  1  request misaligned or req_size = 11.
REQ-018 err_sticky  out  1  set by any errored request; cleared only by reset.

Function
REQ-019 FSM states IDLE, WAIT, RESP; one request outstanding at most.
REQ-020 req_ready SHALL be 1 only in IDLE and is independent of req_valid.
REQ-021 Acceptance = req_valid & req_ready on a rising edge; request fields are sampled only at that edge.
REQ-022 Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=00, SHALL be flagged as an error.
REQ-023 Errored request: no array write; response rsp_err=1, rsp_rdata=0, after the same latency as a load.
REQ-024 Store: byte lanes written at the acceptance edge only (byte: lane addr[1:0]; half: lanes addr[1]*2 and addr[1]*2+1; word: all four); other lanes unchanged.
REQ-025 Store response: rsp_valid asserted the cycle after acceptance (READ_LATENCY ignored), with rsp_err=0 and rsp_rdata=0.
REQ-026 Load: rsp_valid asserted exactly READ_LATENCY cycles after acceptance; READ_LATENCY=2 passes through WAIT for one cycle.
REQ-027 Load data: selected byte or halfword shifted to bits 7:0 or 15:0, then sign- or zero-extended per req_signed; word loads ignore req_signed.
REQ-028 RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_valid & rsp_ready, then returns to IDLE the next cycle.
REQ-029 Back-to-back: a new request is accepted no earlier than the cycle after the response handshake.
REQ-030 A load following a store to the same word SHALL return the stored data (no stale read).
REQ-031 Outside RESP, rsp_valid SHALL be 0 and rsp_rdata and rsp_err SHALL be 0.

Reset
REQ-032 Reset asserted at any time SHALL immediately force IDLE, req_ready=1 (0 while reset is held is also acceptable; it SHALL be 1 in the first cycle after release), rsp_valid=0, rsp_rdata=0, rsp_err=0, err_sticky=0.
REQ-033 Reset SHALL NOT alter array contents; any in-flight response is discarded, and a store already committed at its acceptance edge remains.

Structure
REQ-034 Package data_mem_pkg holds the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD), the FSM state type and the legal READ_LATENCY values.
REQ-035 Sub-module data_mem_bank holds the byte-enabled DEPTH x 32 array with synchronous write and read and the INIT_FILE load; the FSM, alignment check and extension logic stay in data_mem_ctrl.

Verification
REQ-036 Store word 0xDEADBEEF @0x10, then load unsigned byte @0x11 -> rsp_rdata=0x000000BE, rsp_err=0.
REQ-037 Load signed half @0x12 after REQ-036 -> 0xFFFFDEAD; the unsigned load -> 0x0000DEAD.
REQ-038 Store byte 0x55 @0x13, then load word @0x10 -> 0x55ADBEEF.
REQ-039 Load word @0x02 -> rsp_err=1, rsp_rdata=0, err_sticky=1, array unchanged; repeat with req_size=11 -> rsp_err=1.
REQ-040 READ_LATENCY=2 with rsp_ready held 0 for 3 cycles -> rsp_valid rises 2 cycles after acceptance, response stable, req_ready=0 until the handshake.
REQ-041 Assert reset while in WAIT -> rsp_valid=0 immediately, IDLE after release, and earlier stored data still readable.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states,
// legal read latencies and the request legality check.
package data_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Misaligned half/word accesses and the reserved size encoding are errors.
  function automatic logic bad_request(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b1;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_bank.sv
// DEPTH x 32 byte-enabled array, synchronous write and registered read (1 cycle).
// No flow control; contents are never touched by reset.
module data_mem_bank #(
  parameter int DEPTH = 1024,
  parameter INIT_FILE = "",
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [3:0]    be_i,
  input  logic [IW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Every word starts at zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
  end

  always @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

  // Read register only updates on a load, so it holds across WAIT/RESP.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding load/store controller: stores respond in 1 cycle, loads/errors in READ_LATENCY;
// req_ready only in IDLE, response held until rsp_ready.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int READ_LATENCY = 1,
  parameter INIT_FILE = "",
  localparam int AW = $clog2(DEPTH) + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          err_sticky
);

  state_t      state_q, state_d;
  logic [1:0]  size_q, off_q;
  logic        sign_q, we_q, err_q, sticky_q;
  logic        accept, req_err;
  logic [3:0]  be;
  logic [31:0] wlanes, bank_rdata, load_ext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign req_err   = bad_request(req_size, req_addr[1:0]);

  always_comb begin
    be     = 4'b0000;
    wlanes = req_wdata;
    case (req_size)
      SIZE_BYTE: begin
        be     = 4'b0001 << req_addr[1:0];
        wlanes = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        be     = req_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{req_wdata[15:0]}};
      end
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
  end

  data_mem_bank #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_bank (
    .clk_i   (clk),
    .we_i    (accept & req_we & ~req_err),
    .re_i    (accept & ~req_we),
    .be_i    (be),
    .addr_i  (req_addr[AW-1:2]),
    .wdata_i (wlanes),
    .rdata_o (bank_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      size_q   <= 2'b00;
      off_q    <= 2'b00;
      sign_q   <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q <= req_size;
        off_q  <= req_addr[1:0];
        sign_q <= req_signed;
        we_q   <= req_we;
        err_q  <= req_err;
      end
      if (accept && req_err) sticky_q <= 1'b1;
    end
  end

  // Clean stores skip the read pipeline; loads and errors share its latency.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_we && !req_err)                 state_d = ST_RESP;
          else if (READ_LATENCY > READ_LATENCY_MIN) state_d = ST_WAIT;
          else                                      state_d = ST_RESP;
        end
      end
      ST_WAIT: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_v   = bank_rdata[{off_q, 3'b000} +: 8];
    half_v   = off_q[1] ? bank_rdata[31:16] : bank_rdata[15:0];
    load_ext = 32'h0;
    case (size_q)
      SIZE_BYTE: load_ext = {{24{sign_q & byte_v[7]}}, byte_v};
      SIZE_HALF: load_ext = {{16{sign_q & half_v[15]}}, half_v};
      SIZE_WORD: load_ext = bank_rdata;
      default:   load_ext = 32'h0;
    endcase
  end

  always_comb begin
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;
    if (state_q == ST_RESP) begin
      rsp_valid = 1'b1;
      rsp_err   = err_q;
      if (!we_q && !err_q) rsp_rdata = load_ext;
    end
  end

  assign err_sticky = sticky_q;

endmodule
